// File: rtl/control_sequencer_if.sv
`default_nettype none
// ============================================================================
// control_sequencer_if : IR / memory handshake inputs and control-strobe bus
//                        between the sequencer (master) and the datapath.
// Revision: 1.0
// ============================================================================
interface control_sequencer_if;
  logic [31:0] IR;
  logic        mem_ready;

  logic        PC_out;
  logic        MAR_enable;
  logic        IncPC;
  logic        PC_enable;

  logic        Read;
  logic        MDR_enable;
  logic        MDR_out;
  logic        IR_enable;

  logic        Y_enable;
  logic        Z_enable;
  logic        ZLow_out;
  logic        ZHigh_out;
  logic        HI_enable;
  logic        LO_enable;

  logic        Gra;
  logic        Grb;
  logic        Grc;
  logic        Rin;
  logic        Rout;

  logic [4:0]  opcode;
  logic        run;
  logic        done;
  logic        illegal;

  modport master (
    input  IR, mem_ready,
    output PC_out, MAR_enable, IncPC, PC_enable,
    output Read, MDR_enable, MDR_out, IR_enable,
    output Y_enable, Z_enable, ZLow_out, ZHigh_out, HI_enable, LO_enable,
    output Gra, Grb, Grc, Rin, Rout,
    output opcode, run, done, illegal
  );

  modport slave (
    output IR, mem_ready,
    input  PC_out, MAR_enable, IncPC, PC_enable,
    input  Read, MDR_enable, MDR_out, IR_enable,
    input  Y_enable, Z_enable, ZLow_out, ZHigh_out, HI_enable, LO_enable,
    input  Gra, Grb, Grc, Rin, Rout,
    input  opcode, run, done, illegal
  );
endinterface
`default_nettype wire

// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
// control_sequencer : hardwired fetch/execute control unit for the single-bus
//                     datapath (register-to-register ALU instructions).
// Revision: 1.0
// ============================================================================
module control_sequencer (
  input  logic                clk,
  input  logic                clr,
  control_sequencer_if.master bus
);

  localparam logic [4:0] c_op_add  = 5'b00011;
  localparam logic [4:0] c_op_sub  = 5'b00100;
  localparam logic [4:0] c_op_shr  = 5'b00101;
  localparam logic [4:0] c_op_shra = 5'b00110;
  localparam logic [4:0] c_op_shl  = 5'b00111;
  localparam logic [4:0] c_op_ror  = 5'b01000;
  localparam logic [4:0] c_op_rol  = 5'b01001;
  localparam logic [4:0] c_op_and  = 5'b01010;
  localparam logic [4:0] c_op_or   = 5'b01011;
  localparam logic [4:0] c_op_div  = 5'b01111;
  localparam logic [4:0] c_op_mul  = 5'b10000;
  localparam logic [4:0] c_op_neg  = 5'b10001;
  localparam logic [4:0] c_op_not  = 5'b10010;
  localparam logic [4:0] c_op_nop  = 5'b11010;
  localparam logic [4:0] c_op_halt = 5'b11011;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_T0     = 4'd1,
    S_T1     = 4'd2,
    S_T2     = 4'd3,
    S_T3     = 4'd4,
    S_T4     = 4'd5,
    S_T5     = 4'd6,
    S_T6     = 4'd7,
    S_HALTED = 4'd8
  } state_t;

  state_t state_q, state_d;
  logic   illegal_q, illegal_d;

  logic [4:0] w_op;
  logic       w_cls_three;
  logic       w_cls_hilo;
  logic       w_cls_two;
  logic       w_op_nop;
  logic       w_op_halt;
  logic       w_exec;
  logic       w_unsupported;

  // Register fields are routed to the select/encode logic downstream; only the
  // opcode influences sequencing here.
  logic unused_ir_fields;
  assign unused_ir_fields = ^bus.IR[26:0];

  assign w_op = bus.IR[31:27];

  always_comb begin
    w_cls_three = 1'b0;
    w_cls_hilo  = 1'b0;
    w_cls_two   = 1'b0;
    w_op_nop    = 1'b0;
    w_op_halt   = 1'b0;
    case (w_op)
      c_op_add, c_op_sub, c_op_shr, c_op_shra, c_op_shl,
      c_op_ror, c_op_rol, c_op_and, c_op_or:  w_cls_three = 1'b1;
      c_op_div, c_op_mul:                     w_cls_hilo  = 1'b1;
      c_op_neg, c_op_not:                     w_cls_two   = 1'b1;
      c_op_nop:                               w_op_nop    = 1'b1;
      c_op_halt:                              w_op_halt   = 1'b1;
      default: ;
    endcase
  end

  assign w_exec        = w_cls_three | w_cls_hilo | w_cls_two;
  assign w_unsupported = ~(w_exec | w_op_nop | w_op_halt);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q   <= S_IDLE;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    case (state_q)
      S_IDLE: state_d = S_T0;
      S_T0:   state_d = S_T1;
      S_T1: begin
        if (bus.mem_ready) state_d = S_T2;
      end
      S_T2: begin
        if (w_op_halt) begin
          state_d = S_HALTED;
        end else if (w_exec) begin
          state_d = S_T3;
        end else begin
          // nop and unsupported opcodes both retire here; only the latter flag
          state_d = S_T0;
          if (w_unsupported) illegal_d = 1'b1;
        end
      end
      S_T3:     state_d = S_T4;
      S_T4:     state_d = S_T5;
      S_T5:     state_d = w_cls_hilo ? S_T6 : S_T0;
      S_T6:     state_d = S_T0;
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase
  end

  logic       w_pc_out, w_mar_enable, w_inc_pc, w_pc_enable;
  logic       w_read, w_mdr_enable, w_mdr_out, w_ir_enable;
  logic       w_y_enable, w_z_enable, w_zlow_out, w_zhigh_out;
  logic       w_hi_enable, w_lo_enable;
  logic       w_gra, w_grb, w_grc, w_rin, w_rout;
  logic [4:0] w_opcode;
  logic       w_done;

  always_comb begin
    w_pc_out     = 1'b0;
    w_mar_enable = 1'b0;
    w_inc_pc     = 1'b0;
    w_pc_enable  = 1'b0;
    w_read       = 1'b0;
    w_mdr_enable = 1'b0;
    w_mdr_out    = 1'b0;
    w_ir_enable  = 1'b0;
    w_y_enable   = 1'b0;
    w_z_enable   = 1'b0;
    w_zlow_out   = 1'b0;
    w_zhigh_out  = 1'b0;
    w_hi_enable  = 1'b0;
    w_lo_enable  = 1'b0;
    w_gra        = 1'b0;
    w_grb        = 1'b0;
    w_grc        = 1'b0;
    w_rin        = 1'b0;
    w_rout       = 1'b0;
    w_opcode     = 5'b00000;
    w_done       = 1'b0;
    case (state_q)
      S_T0: begin
        w_pc_out     = 1'b1;
        w_mar_enable = 1'b1;
        w_inc_pc     = 1'b1;
        w_pc_enable  = 1'b1;
      end
      S_T1: begin
        w_read       = 1'b1;
        w_mdr_enable = 1'b1;
      end
      S_T2: begin
        w_mdr_out   = 1'b1;
        w_ir_enable = 1'b1;
        w_done      = ~(w_exec | w_op_halt);
      end
      S_T3: begin
        w_grb      = 1'b1;
        w_rout     = 1'b1;
        w_y_enable = 1'b1;
      end
      S_T4: begin
        w_rout     = 1'b1;
        w_z_enable = 1'b1;
        w_opcode   = w_op;
        // single-source ops read Rb again; everything else takes Rc
        if (w_cls_two) w_grb = 1'b1;
        else           w_grc = 1'b1;
      end
      S_T5: begin
        w_zlow_out = 1'b1;
        if (w_cls_hilo) begin
          w_lo_enable = 1'b1;
        end else begin
          w_gra  = 1'b1;
          w_rin  = 1'b1;
          w_done = 1'b1;
        end
      end
      S_T6: begin
        w_zhigh_out = 1'b1;
        w_hi_enable = 1'b1;
        w_done      = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.PC_out     = w_pc_out;
  assign bus.MAR_enable = w_mar_enable;
  assign bus.IncPC      = w_inc_pc;
  assign bus.PC_enable  = w_pc_enable;
  assign bus.Read       = w_read;
  assign bus.MDR_enable = w_mdr_enable;
  assign bus.MDR_out    = w_mdr_out;
  assign bus.IR_enable  = w_ir_enable;
  assign bus.Y_enable   = w_y_enable;
  assign bus.Z_enable   = w_z_enable;
  assign bus.ZLow_out   = w_zlow_out;
  assign bus.ZHigh_out  = w_zhigh_out;
  assign bus.HI_enable  = w_hi_enable;
  assign bus.LO_enable  = w_lo_enable;
  assign bus.Gra        = w_gra;
  assign bus.Grb        = w_grb;
  assign bus.Grc        = w_grc;
  assign bus.Rin        = w_rin;
  assign bus.Rout       = w_rout;
  assign bus.opcode     = w_opcode;
  assign bus.done       = w_done;
  assign bus.run        = (state_q != S_HALTED);
  assign bus.illegal    = illegal_q;

endmodule
`default_nettype wire
